// File: rtl/tpu_pkg.sv
// Shared constants, FSM state type and helpers for the TPU instruction buffer.
// Keeps opcode/NOP encodings in one place for the buffer and its memory.
package tpu_pkg;

  localparam int          IMEM_DEPTH = 32;
  localparam int          IMEM_AW    = 5;
  localparam logic [5:0]  HALT_OPC   = 6'h3F;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_e;

  // Program length after writing slot addr: max(len, addr+1).
  function automatic logic [5:0] grow_len(input logic [5:0] len, input logic [4:0] addr);
    logic [5:0] cand;
    cand = {1'b0, addr} + 6'd1;
    return (cand > len) ? cand : len;
  endfunction

endpackage

// File: rtl/tpu_imem_1r1w.sv
// 32x32 instruction store: one write port, one registered read port (1-cycle latency).
// The read register can return NOP instead of a stored word and holds when not read.
module tpu_imem_1r1w
  import tpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [IMEM_AW-1:0]  waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic                re_i,
  input  logic [IMEM_AW-1:0]  raddr_i,
  input  logic                rnop_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem_q [IMEM_DEPTH];
  logic [31:0] rdata_q;

  // Array carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rnop_i ? NOP_WORD : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tpu_instr_buffer.sv
// Instruction buffer: UART-loaded program store plus IDLE/RUN/DONE execution FSM.
// Fetches return one cycle later, one per cycle; writes during RUN are rejected.
module tpu_instr_buffer
  import tpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic        abort,
  input  logic        fetch_en,
  input  logic [7:0]  fetch_addr,
  output logic [31:0] instr_data,
  output logic        instr_valid,
  output logic        exec_active,
  output logic        exec_done,
  output logic        fetch_oob,
  output logic        wr_blocked,
  output logic [5:0]  prog_len,
  output logic [15:0] exec_cycles
);

  exec_state_e state_q, state_d;
  logic [5:0]  prog_len_q, prog_len_d, eff_len;
  logic [15:0] exec_cycles_q, exec_cycles_d;
  logic        instr_valid_q, fetch_oob_q, wr_blocked_q, exec_active_q, exec_done_q;
  logic        in_run, halt_hit, wr_ok, fetch_go, fetch_in_range;

  always_comb begin
    in_run         = (state_q == ST_RUN);
    halt_hit       = in_run && instr_valid_q && (instr_data[31:26] == HALT_OPC);
    wr_ok          = wr_en && !in_run;
    eff_len        = wr_ok ? grow_len(prog_len_q, wr_addr) : prog_len_q;
    fetch_in_range = ({2'b00, prog_len_q} > fetch_addr);
    // A fetch in the HALT cycle is dropped; abort outranks everything.
    fetch_go       = in_run && fetch_en && !abort && !halt_hit;
    prog_len_d     = eff_len;
    state_d        = state_q;
    exec_cycles_d  = exec_cycles_q;
    if (in_run && (exec_cycles_q != 16'hFFFF)) exec_cycles_d = exec_cycles_q + 16'd1;

    if (abort) begin
      state_d = ST_IDLE;
    end else if (in_run) begin
      if (halt_hit) state_d = ST_DONE;
    end else if (start) begin
      exec_cycles_d = '0;
      state_d       = (eff_len != 6'd0) ? ST_RUN : ST_DONE;
    end else if (wr_ok && (state_q == ST_DONE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      prog_len_q    <= '0;
      exec_cycles_q <= '0;
      instr_valid_q <= 1'b0;
      fetch_oob_q   <= 1'b0;
      wr_blocked_q  <= 1'b0;
      exec_active_q <= 1'b0;
      exec_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_len_q    <= prog_len_d;
      exec_cycles_q <= exec_cycles_d;
      instr_valid_q <= fetch_go;
      fetch_oob_q   <= fetch_go && !fetch_in_range;
      wr_blocked_q  <= wr_en && in_run;
      exec_active_q <= (state_d == ST_RUN);
      exec_done_q   <= (state_d == ST_DONE);
    end
  end

  tpu_imem_1r1w u_imem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (fetch_go),
    .raddr_i (fetch_addr[4:0]),
    .rnop_i  (!fetch_in_range),
    .rdata_o (instr_data)
  );

  assign instr_valid = instr_valid_q;
  assign fetch_oob   = fetch_oob_q;
  assign wr_blocked  = wr_blocked_q;
  assign prog_len    = prog_len_q;
  assign exec_cycles = exec_cycles_q;
  assign exec_active = exec_active_q;
  assign exec_done   = exec_done_q;

endmodule

// File: tb/tb_tpu_instr_buffer.sv
// Directed + randomized bench for tpu_instr_buffer against a cycle-level reference model.
module tb_tpu_instr_buffer;

  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, start, abort, fetch_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  fetch_addr;
  logic [31:0] instr_data;
  logic        instr_valid, exec_active, exec_done, fetch_oob, wr_blocked;
  logic [5:0]  prog_len;
  logic [15:0] exec_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  int          m_st, m_len, m_cyc;
  logic [31:0] m_data;
  bit          m_valid, m_oob, m_blk;

  always #5 clk = ~clk;

  tpu_instr_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .abort       (abort),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .exec_active (exec_active),
    .exec_done   (exec_done),
    .fetch_oob   (fetch_oob),
    .wr_blocked  (wr_blocked),
    .prog_len    (prog_len),
    .exec_cycles (exec_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_len = 0; m_cyc = 0;
    m_data = 32'h0; m_valid = 0; m_oob = 0; m_blk = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit          halt, wr_ok, n_valid, n_oob;
    int          eff, n_st;
    logic [31:0] n_data;
    halt  = (m_st == RUN) && m_valid && (m_data[31:26] == 6'h3F);
    wr_ok = wr_en && (m_st != RUN);
    eff   = m_len;
    if (wr_ok && (int'(wr_addr) + 1 > m_len)) eff = int'(wr_addr) + 1;
    n_st = m_st; n_data = m_data; n_valid = 0; n_oob = 0;
    if (abort) n_st = IDLE;
    else if (m_st == RUN) begin
      if (halt) n_st = DONE;
      else if (fetch_en) begin
        n_valid = 1;
        if (int'(fetch_addr) < m_len) n_data = m_mem[fetch_addr[4:0]];
        else begin n_data = 32'h0; n_oob = 1; end
      end
    end else if (start) n_st = (eff > 0) ? RUN : DONE;
    else if (wr_ok && m_st == DONE) n_st = IDLE;
    if (m_st == RUN) begin
      if (m_cyc < 65535) m_cyc++;
    end else if (start && !abort) m_cyc = 0;
    m_blk = wr_en && (m_st == RUN);
    if (wr_ok) begin m_mem[wr_addr] = wr_data; m_len = eff; end
    m_st = n_st; m_data = n_data; m_valid = n_valid; m_oob = n_oob;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":instr_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
    chk({tag, ":instr_data"},  instr_data, m_data);
    chk({tag, ":fetch_oob"},   {31'b0, fetch_oob},   {31'b0, m_oob});
    chk({tag, ":wr_blocked"},  {31'b0, wr_blocked},  {31'b0, m_blk});
    chk({tag, ":prog_len"},    {26'b0, prog_len},    32'(m_len));
    chk({tag, ":exec_cycles"}, {16'b0, exec_cycles}, 32'(m_cyc));
    chk({tag, ":exec_active"}, {31'b0, exec_active}, {31'b0, (m_st == RUN)});
    chk({tag, ":exec_done"},   {31'b0, exec_done},   {31'b0, (m_st == DONE)});
  endtask

  task automatic idle_inputs();
    wr_en = 0; start = 0; abort = 0; fetch_en = 0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] d, input string tag);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle_inputs(); wr_addr = 0; wr_data = 0; fetch_addr = 0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #2; rst_n = 1;

    // Empty program: start goes straight to DONE
    start = 1; tick("empty_start");
    chk("empty_done", {31'b0, exec_done}, 32'd1);
    chk("empty_cycles", {16'b0, exec_cycles}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick("empty_idle");
      chk("empty_novalid", {31'b0, instr_valid}, 32'd0);
    end

    // Load and run to HALT
    write_word(5'd0, 32'h1111_1111, "load0");
    chk("load_leaves_done", {31'b0, exec_done}, 32'd0);
    write_word(5'd1, 32'h2222_2222, "load1");
    write_word(5'd2, 32'hFC00_0000, "load2");
    chk("prog_len_3", {26'b0, prog_len}, 32'd3);
    start = 1; tick("start_run");
    chk("run_active", {31'b0, exec_active}, 32'd1);
    fetch_en = 1; fetch_addr = 8'd0; tick("fetch0");
    chk("fetch0_word", instr_data, 32'h1111_1111);
    fetch_en = 1; fetch_addr = 8'd1; tick("fetch1");
    chk("fetch1_word", instr_data, 32'h2222_2222);
    fetch_en = 1; fetch_addr = 8'd2; tick("fetch2");
    chk("fetch2_word", instr_data, 32'hFC00_0000);
    chk("fetch2_valid", {31'b0, instr_valid}, 32'd1);
    fetch_en = 1; fetch_addr = 8'd0; tick("halt");
    chk("halt_done", {31'b0, exec_done}, 32'd1);
    chk("halt_inactive", {31'b0, exec_active}, 32'd0);
    chk("halt_fetch_dropped", {31'b0, instr_valid}, 32'd0);

    // Blocked write and out-of-range fetch
    start = 1; tick("restart");
    write_word(5'd0, 32'hDEAD_BEEF, "blocked_wr");
    chk("blocked_pulse", {31'b0, wr_blocked}, 32'd1);
    fetch_en = 1; fetch_addr = 8'd7; tick("oob");
    chk("blocked_one_cycle", {31'b0, wr_blocked}, 32'd0);
    chk("oob_flag", {31'b0, fetch_oob}, 32'd1);
    chk("oob_nop", instr_data, 32'h0);
    chk("oob_still_run", {31'b0, exec_active}, 32'd1);
    fetch_en = 1; fetch_addr = 8'd0; tick("after_block");
    chk("orig_word_kept", instr_data, 32'h1111_1111);

    // Abort beats fetch
    abort = 1; fetch_en = 1; fetch_addr = 8'd1; tick("abort");
    chk("abort_novalid", {31'b0, instr_valid}, 32'd0);
    chk("abort_idle", {31'b0, exec_active | exec_done}, 32'd0);
    chk("abort_len", {26'b0, prog_len}, 32'd3);

    // Reset while a fetch is pending
    start = 1; tick("start_for_rst");
    fetch_en = 1; fetch_addr = 8'd1;
    #2; rst_n = 0; #1;
    model_reset();
    check_all("rst_mid");
    idle_inputs();
    @(posedge clk); #1;
    check_all("rst_hold");
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick("post_rst");
      chk("post_rst_novalid", {31'b0, instr_valid}, 32'd0);
    end

    // Randomized traffic; writes stay contiguous so every in-range slot is defined
    begin
      int n;
      logic [31:0] d;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        if (d[31:26] == 6'h3F) d[31] = 1'b0;
        write_word(5'(i), d, "rand_load");
      end
      for (int i = 0; i < 600; i++) begin
        fetch_en   = ($urandom_range(0, 99) < 70);
        fetch_addr = 8'($urandom_range(0, m_len + 4));
        start      = ($urandom_range(0, 9) == 0);
        abort      = ($urandom_range(0, 49) == 0);
        wr_en      = ($urandom_range(0, 9) == 0);
        wr_addr    = 5'($urandom_range(0, (m_len < 31) ? m_len : 31));
        d          = $urandom;
        if ($urandom_range(0, 3) == 0) d[31:26] = 6'h3F;
        wr_data    = d;
        tick("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
